// File: rtl/extreme_scale_detect.sv
// 3x3x3 scale-space extremum detector: per-layer line buffers and 3x3 windows feed a
// three-stage compare pipeline that marks keypoints in every interior DoG layer.
module extreme_scale_detect #(
    parameter int    IMAGE_COLUMN = 512,
    parameter int    IMAGE_ROW    = 512,
    parameter int    NUM_LAYERS   = 5,
    parameter int    DIFF_WIDTH   = 14,
    parameter int    BORDER       = 4,
    parameter string EXTREME_MODE = "both"
) (
    input  logic                             axi_clk,
    input  logic                             axi_rst,
    input  logic                             diff_valid,
    input  logic [NUM_LAYERS*DIFF_WIDTH-1:0] diff_data,
    input  logic                             frame_sync,
    input  logic [DIFF_WIDTH-2:0]            contrast_thresh,
    output logic                             key_valid,
    output logic [NUM_LAYERS-3:0]            key_mark,
    output logic [NUM_LAYERS-3:0]            key_type,
    output logic [$clog2(IMAGE_ROW)-1:0]     key_row,
    output logic [$clog2(IMAGE_COLUMN)-1:0]  key_col
);

    localparam int RW     = $clog2(IMAGE_ROW);
    localparam int CW     = $clog2(IMAGE_COLUMN);
    localparam int NI     = NUM_LAYERS - 2;
    localparam bit MAX_EN = (EXTREME_MODE != "min");
    localparam bit MIN_EN = (EXTREME_MODE != "max");

    logic [RW-1:0] row_q, row_d, beat_row, ctr_row;
    logic [CW-1:0] col_q, col_d, beat_col, ctr_col;
    logic          win_done, in_border;

    // frame_sync coinciding with a beat makes that beat pixel (0,0)
    always_comb begin
        beat_row = frame_sync ? '0 : row_q;
        beat_col = frame_sync ? '0 : col_q;
        row_d    = row_q;
        col_d    = col_q;
        if (diff_valid) begin
            if (beat_col == CW'(IMAGE_COLUMN - 1)) begin
                col_d = '0;
                row_d = (beat_row == RW'(IMAGE_ROW - 1)) ? '0 : beat_row + 1'b1;
            end else begin
                col_d = beat_col + 1'b1;
                row_d = beat_row;
            end
        end else if (frame_sync) begin
            row_d = '0;
            col_d = '0;
        end
        ctr_row   = beat_row - 1'b1;
        ctr_col   = beat_col - 1'b1;
        win_done  = diff_valid && (int'(beat_row) >= 2) && (int'(beat_col) >= 2);
        in_border = (int'(ctr_row) >= BORDER) && (int'(ctr_row) <= IMAGE_ROW - 1 - BORDER) &&
                    (int'(ctr_col) >= BORDER) && (int'(ctr_col) <= IMAGE_COLUMN - 1 - BORDER);
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    // Line buffers and windows hold no reset; rows 0-1 never emit so stale data is masked
    logic        [DIFF_WIDTH-1:0] lb0_mem [NUM_LAYERS][IMAGE_COLUMN];
    logic        [DIFF_WIDTH-1:0] lb1_mem [NUM_LAYERS][IMAGE_COLUMN];
    logic signed [DIFF_WIDTH-1:0] win_q   [NUM_LAYERS][3][3];

    always_ff @(posedge axi_clk) begin
        if (diff_valid) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                lb1_mem[k][beat_col] <= lb0_mem[k][beat_col];
                lb0_mem[k][beat_col] <= diff_data[k*DIFF_WIDTH +: DIFF_WIDTH];
                for (int i = 0; i < 3; i++) begin
                    win_q[k][i][0] <= win_q[k][i][1];
                    win_q[k][i][1] <= win_q[k][i][2];
                end
                win_q[k][0][2] <= lb1_mem[k][beat_col];
                win_q[k][1][2] <= lb0_mem[k][beat_col];
                win_q[k][2][2] <= diff_data[k*DIFF_WIDTH +: DIFF_WIDTH];
            end
        end
    end

    logic                  s1_valid_q, s1_border_q;
    logic [RW-1:0]         s1_row_q;
    logic [CW-1:0]         s1_col_q;
    logic [DIFF_WIDTH-2:0] s1_thresh_q;

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            s1_valid_q  <= 1'b0;
            s1_border_q <= 1'b0;
            s1_row_q    <= '0;
            s1_col_q    <= '0;
            s1_thresh_q <= '0;
        end else begin
            s1_valid_q  <= win_done;
            s1_border_q <= in_border;
            s1_row_q    <= ctr_row;
            s1_col_q    <= ctr_col;
            if (diff_valid) begin
                s1_thresh_q <= contrast_thresh;
            end
        end
    end

    // Index d*9+i*3+j over layers k..k+2; the centre slot (13) is tied high so the
    // AND-reduce only sees the 26 real neighbour compares.
    logic [NI-1:0][26:0]     gt_c, lt_c;
    logic [NI-1:0]           mag_ok_c;
    logic [DIFF_WIDTH:0]     ext_c [NI];
    logic [DIFF_WIDTH:0]     mag_c [NI];

    always_comb begin
        gt_c     = '0;
        lt_c     = '0;
        mag_ok_c = '0;
        for (int k = 0; k < NI; k++) begin
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        gt_c[k][d*9 + i*3 + j] = win_q[k+1][1][1] > win_q[k+d][i][j];
                        lt_c[k][d*9 + i*3 + j] = win_q[k+1][1][1] < win_q[k+d][i][j];
                    end
                end
            end
            gt_c[k][13] = 1'b1;
            lt_c[k][13] = 1'b1;
            ext_c[k]    = {win_q[k+1][1][1][DIFF_WIDTH-1], win_q[k+1][1][1]};
            mag_c[k]    = ext_c[k][DIFF_WIDTH] ? -ext_c[k] : ext_c[k];
            mag_ok_c[k] = mag_c[k] > {2'b00, s1_thresh_q};
        end
    end

    logic                s2_valid_q, s2_border_q;
    logic [NI-1:0][26:0] s2_gt_q, s2_lt_q;
    logic [NI-1:0]       s2_mag_q;
    logic [RW-1:0]       s2_row_q;
    logic [CW-1:0]       s2_col_q;

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            s2_valid_q  <= 1'b0;
            s2_border_q <= 1'b0;
            s2_gt_q     <= '0;
            s2_lt_q     <= '0;
            s2_mag_q    <= '0;
            s2_row_q    <= '0;
            s2_col_q    <= '0;
        end else begin
            s2_valid_q  <= s1_valid_q;
            s2_border_q <= s1_border_q;
            s2_gt_q     <= gt_c;
            s2_lt_q     <= lt_c;
            s2_mag_q    <= mag_ok_c;
            s2_row_q    <= s1_row_q;
            s2_col_q    <= s1_col_q;
        end
    end

    logic [NI-1:0] mark_c, type_c;
    logic [NI-1:0] is_max_c, is_min_c;

    always_comb begin
        mark_c   = '0;
        type_c   = '0;
        is_max_c = '0;
        is_min_c = '0;
        for (int k = 0; k < NI; k++) begin
            is_max_c[k] = (&s2_gt_q[k]) & s2_mag_q[k] & MAX_EN;
            is_min_c[k] = (&s2_lt_q[k]) & s2_mag_q[k] & MIN_EN;
            mark_c[k]   = s2_valid_q & s2_border_q & (is_max_c[k] | is_min_c[k]);
            type_c[k]   = s2_valid_q & s2_border_q & is_max_c[k];
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            key_valid <= 1'b0;
            key_mark  <= '0;
            key_type  <= '0;
            key_row   <= '0;
            key_col   <= '0;
        end else begin
            key_valid <= s2_valid_q;
            key_mark  <= mark_c;
            key_type  <= type_c;
            if (s2_valid_q) begin
                key_row <= s2_row_q;
                key_col <= s2_col_q;
            end
        end
    end

endmodule
